instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream stage of the single-cycle datapath: owns the program counter, fetches 32-bit
//  instruction words over a valid/ready instruction-memory port and presents instruction,
//  pc and pcNext to the execute stage with a valid/ready handshake. Accepts PC redirects
//  (taken branches, jumps) on retire. One outstanding memory request at a time.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC loaded on reset; must be word aligned
// PORTS
//  clk              in   1   clock, all state updates on rising edge
//  reset            in   1   synchronous, active-high reset
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   memory accepts request this cycle
//  imem_addr        out  32  fetch byte address (word aligned)
//  imem_rsp_valid   in   1   response word valid
//  imem_rsp_data    in   32  response instruction word
//  instruction      out  32  instruction presented to execute stage
//  pc               out  32  address of presented instruction
//  pcNext           out  32  pc + 4 (mod 2^32), feeds link-register writeback
//  instr_valid      out  1   instruction/pc/pcNext valid
//  instr_ready      in   1   execute stage retires presented instruction
//  redirect_valid   in   1   next PC is redirect_target (sampled only on retire)
//  redirect_target  in   32  redirect byte address
//  misaligned       out  1   sticky: redirect target had bits[1:0] != 0
//  retire_count     out  32  number of retired instructions, wraps at 2^32
// BEHAVIOUR
//  - Reset (reset=1 at edge): state=FETCH, pc=RESET_PC, instruction=0, misaligned=0,
//    retire_count=0. While reset is high all outputs are driven: imem_req_valid=0,
//    instr_valid=0, imem_addr=RESET_PC, pcNext=RESET_PC+4.
//  - States: FETCH, WAIT, HOLD, ERROR.
//  - FETCH: imem_req_valid=1, imem_addr=pc. imem_addr stable while valid&&!ready.
//    valid&&ready -> WAIT.
//  - WAIT: imem_req_valid=0. imem_rsp_valid=1 -> instruction<=imem_rsp_data, -> HOLD.
//    Response may arrive any cycle >= one after acceptance; unbounded wait allowed.
//  - HOLD: instr_valid=1; instruction, pc, pcNext held stable until retire.
//    Retire = instr_valid&&instr_ready: retire_count+=1 and
//      redirect_valid=0 -> pc<=pc+4, -> FETCH;
//      redirect_valid=1, target[1:0]==0 -> pc<=redirect_target, -> FETCH;
//      redirect_valid=1, target[1:0]!=0 -> misaligned<=1, pc unchanged, -> ERROR.
//  - ERROR: imem_req_valid=0, instr_valid=0; held until reset.
//  - redirect_valid outside a retire cycle is ignored. imem_rsp_valid outside WAIT is
//    ignored (covers stale responses after reset).
//  - pcNext = pc + 32'd4 combinational, wraps 32'hFFFF_FFFC -> 32'h0000_0000.
//  - Latency: request accepted cycle N, response cycle M>N, instr_valid from M+1; with
//    zero-wait memory and instr_ready=1 throughput is one instruction per 3 cycles.
//  - Reset mid-operation (any state) aborts the outstanding request; no partial update.
// TESTING
//  1. RESET_PC=0x100, reset 2 cycles, ready=1, rsp 0x00500093 next cycle -> addr 0x100,
//     then instr_valid=1, instruction=0x00500093, pc=0x100, pcNext=0x104.
//  2. instr_ready=0 for 5 cycles in HOLD -> outputs stable, imem_req_valid=0; then
//     instr_ready=1 -> next request addr 0x104, retire_count=1.
//  3. imem_req_ready=0 for 3 cycles -> imem_req_valid=1, imem_addr constant throughout.
//  4. Retire with redirect_valid=1, target 0x200 -> next imem_addr=0x200, pc=0x200;
//     target 0x202 -> misaligned=1, no further requests until reset.
//  5. pc=0xFFFF_FFFC presented -> pcNext=0x0; retire -> next imem_addr=0x0.
//  6. reset asserted in WAIT, stale rsp_valid the cycle after reset release -> ignored;
//     fresh request to RESET_PC issued, retire_count=0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Bundles the instruction-memory port and the execute-stage handshake of the fetch unit.
// The master side is the fetch unit. The slave side is its environment (memory plus execute).
interface instruction_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misaligned;
    logic [31:0] retire_count;

    modport master (
        output imem_req_valid, imem_addr, instruction, pc, pcNext, instr_valid, misaligned,
               retire_count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid,
               redirect_target
    );

    modport slave (
        input  imem_req_valid, imem_addr, instruction, pc, pcNext, instr_valid, misaligned,
               retire_count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid,
               redirect_target
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program-counter owner: fetches one word at a time over the imem port and holds it for the
// execute stage until retire, applying redirects and trapping on misaligned targets.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                       clk,
    input logic                       reset,
    instruction_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {StFetch, StWait, StHold, StError} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic        mis_q, mis_d;
    logic [31:0] pc_cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            count_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        mis_d   = mis_q;
        case (state_q)
            StFetch: begin
                if (bus.imem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (bus.imem_rsp_valid) begin
                    instr_d = bus.imem_rsp_data;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.instr_ready) begin
                    count_d = count_q + 32'd1;
                    if (!bus.redirect_valid) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = StFetch;
                    end else if (bus.redirect_target[1:0] == 2'b00) begin
                        pc_d    = bus.redirect_target;
                        state_d = StFetch;
                    end else begin
                        // pc stays on the offending instruction for post-mortem inspection
                        mis_d   = 1'b1;
                        state_d = StError;
                    end
                end
            end
            default: state_d = StError;
        endcase
    end

    // Outputs are forced to their reset view while reset is high, even before the first edge.
    assign pc_cur             = reset ? RESET_PC : pc_q;
    assign bus.imem_req_valid = !reset && (state_q == StFetch);
    assign bus.imem_addr      = pc_cur;
    assign bus.pc             = pc_cur;
    assign bus.pcNext         = pc_cur + 32'd4;
    assign bus.instr_valid    = !reset && (state_q == StHold);
    assign bus.instruction    = instr_q;
    assign bus.misaligned     = mis_q;
    assign bus.retire_count   = count_q;

endmodule
